// File: rtl/mpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_pkg
//  Brief    : Shared definitions for the 8-bit MIPS MPU front end: opcode
//             classes, instruction field positions, fetch FSM state encoding
//             and default widths.
//  Revision : 1.0  initial release
// ============================================================================
package mpu_pkg;

   // Default widths
   localparam int PC_W_DEF    = 8;
   localparam int INSTR_W_DEF = 16;

   // Opcode classes held in instr[15:13]
   localparam logic [2:0] OPC_R    = 3'b000;
   localparam logic [2:0] OPC_ADDI = 3'b001;
   localparam logic [2:0] OPC_LW   = 3'b010;
   localparam logic [2:0] OPC_SW   = 3'b011;
   localparam logic [2:0] OPC_BEQ  = 3'b100;
   localparam logic [2:0] OPC_J    = 3'b101;

   // opFn[4:3] value that no legal opcode class produces
   localparam logic [1:0] CLASS_ILLEGAL = 2'b11;

   // Instruction field bit positions
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 13;
   localparam int RS_MSB  = 12;
   localparam int RS_LSB  = 10;
   localparam int RT_MSB  = 9;
   localparam int RT_LSB  = 7;
   localparam int RD_MSB  = 6;
   localparam int RD_LSB  = 4;
   localparam int IMM_MSB = 6;
   localparam int IMM_LSB = 0;
   localparam int JT_MSB  = 7;
   localparam int JT_LSB  = 0;
   localparam int FN_MSB  = 1;
   localparam int FN_LSB  = 0;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_t;

   // True when the opFn belongs to the reserved class
   function automatic logic is_illegal(input logic [4:0] op_fn);
      return (op_fn[4:3] == CLASS_ILLEGAL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Brief    : Instruction-memory request/valid bus between the fetch unit
//             (master) and instruction memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16
) ();

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_valid;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_valid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_valid,
      output imem_rdata
   );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next
//  Brief    : Combinational next-PC selector. Sequential, taken-branch and
//             jump targets; reserved opcodes always fall through to pc+1.
//             All arithmetic wraps modulo 2^PC_W.
//  Revision : 1.0  initial release
// ============================================================================
module pc_next #(
   parameter int PC_W = 8
) (
   input  wire logic [PC_W-1:0] pc_i,
   input  wire logic [7:0]      imm_i,
   input  wire logic [7:0]      jmp_tgt_i,
   input  wire logic            br_i,
   input  wire logic            nia_i,
   input  wire logic            alu_zero_i,
   input  wire logic            illegal_i,
   output logic      [PC_W-1:0] pc_next_o
);

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] imm_ext;
   logic [PC_W-1:0] jmp_ext;

   assign pc_inc  = pc_i + PC_W'(1);
   assign imm_ext = PC_W'($signed(imm_i));
   assign jmp_ext = PC_W'(jmp_tgt_i);

   // Priority: reserved opcode, then nia, then branch, else jump
   always_comb begin
      pc_next_o = pc_inc;
      if (illegal_i || nia_i) begin
         pc_next_o = pc_inc;
      end else if (br_i) begin
         pc_next_o = alu_zero_i ? (pc_inc + imm_ext) : pc_inc;
      end else begin
         pc_next_o = jmp_ext;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction fetch and sequencing unit. Owns the PC, fetches
//             16-bit instructions over a req/valid handshake, presents the
//             decoded fields and selects the next PC on ex_done.
//             Optional feature macro: FETCH_TRAP_EN (halt on reserved opcode).
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
   import mpu_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              INSTR_W  = INSTR_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  wire logic            clk,
   input  wire logic            rst,
   fetch_unit_if.master         imem,
   input  wire logic            ex_done,
   input  wire logic            br,
   input  wire logic            nia,
   input  wire logic            alu_zero,
   output logic                 instr_valid,
   output logic [4:0]           opFn,
   output logic [2:0]           rs,
   output logic [2:0]           rt,
   output logic [2:0]           rd,
   output logic [7:0]           imm,
   output logic [PC_W-1:0]      pc,
   output logic                 halted
);

   fetch_state_t       state_q;
   logic [PC_W-1:0]    pc_q;
   logic [INSTR_W-1:0] ir_q;
   logic               req_q;
   logic               ivalid_q;

   logic [PC_W-1:0]    pc_d;
   logic               illegal;
   logic               trap_hit;

   // Field decode straight from the instruction register; fields hold their
   // last value whenever instr_valid is low.
   assign opFn    = {ir_q[OPC_MSB:OPC_LSB], ir_q[FN_MSB:FN_LSB]};
   assign rs      = ir_q[RS_MSB:RS_LSB];
   assign rt      = ir_q[RT_MSB:RT_LSB];
   assign rd      = ir_q[RD_MSB:RD_LSB];
   assign imm     = {ir_q[IMM_MSB], ir_q[IMM_MSB:IMM_LSB]};
   assign illegal = is_illegal(opFn);

`ifdef FETCH_TRAP_EN
   assign trap_hit = illegal;
   assign halted   = (state_q == ST_HALT);
`else
   assign trap_hit = 1'b0;
   assign halted   = 1'b0;
`endif

   // req_q already reflects the post-reset FETCH state; masking with rst
   // keeps the request low during the reset cycle itself.
   assign imem.imem_req  = req_q & ~rst;
   assign imem.imem_addr = pc_q;
   assign instr_valid    = ivalid_q;
   assign pc             = pc_q;

   pc_next #(
      .PC_W (PC_W)
   ) u_pc_next (
      .pc_i       (pc_q),
      .imm_i      (imm),
      .jmp_tgt_i  (ir_q[JT_MSB:JT_LSB]),
      .br_i       (br),
      .nia_i      (nia),
      .alu_zero_i (alu_zero),
      .illegal_i  (illegal),
      .pc_next_o  (pc_d)
   );

   // Fetch/issue sequencer with registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         req_q    <= 1'b1;
         ivalid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               req_q <= 1'b1;
               if (imem.imem_valid) begin
                  ir_q     <= imem.imem_rdata;
                  req_q    <= 1'b0;
                  ivalid_q <= 1'b1;
                  state_q  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (trap_hit) begin
                  ivalid_q <= 1'b0;
                  state_q  <= ST_HALT;
               end else if (ex_done) begin
                  pc_q     <= pc_d;
                  req_q    <= 1'b1;
                  ivalid_q <= 1'b0;
                  state_q  <= ST_FETCH;
               end
            end
            ST_HALT: begin
               req_q    <= 1'b0;
               ivalid_q <= 1'b0;
            end
            default: begin
               req_q    <= 1'b0;
               ivalid_q <= 1'b0;
               state_q  <= ST_HALT;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Directed self-checking bench for fetch_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

   logic       clk;
   logic       rst;
   logic       ex_done;
   logic       br;
   logic       nia;
   logic       alu_zero;
   logic       instr_valid;
   logic [4:0] opFn;
   logic [2:0] rs;
   logic [2:0] rt;
   logic [2:0] rd;
   logic [7:0] imm;
   logic [7:0] pc;
   logic       halted;

   int n_checks;
   int n_errors;

   fetch_unit_if #(.PC_W(8), .INSTR_W(16)) imem_bus ();

   fetch_unit #(
      .PC_W     (8),
      .INSTR_W  (16),
      .RESET_PC (8'h00)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (imem_bus),
      .ex_done     (ex_done),
      .br          (br),
      .nia         (nia),
      .alu_zero    (alu_zero),
      .instr_valid (instr_valid),
      .opFn        (opFn),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .imm         (imm),
      .pc          (pc),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction after 'dly' idle request cycles at address 'addr'
   task automatic fetch(input int dly, input logic [15:0] ins, input logic [7:0] addr);
      for (int i = 0; i < dly; i++) begin
         chk("req_wait", imem_bus.imem_req, 1'b1);
         chk("addr_wait", imem_bus.imem_addr, addr);
         chk("iv_wait", instr_valid, 1'b0);
         tick();
      end
      chk("req", imem_bus.imem_req, 1'b1);
      chk("addr", imem_bus.imem_addr, addr);
      imem_bus.imem_valid = 1'b1;
      imem_bus.imem_rdata = ins;
      tick();
      imem_bus.imem_valid = 1'b0;
      imem_bus.imem_rdata = 16'hFFFF;
      chk("iv_rise", instr_valid, 1'b1);
      chk("req_drop", imem_bus.imem_req, 1'b0);
   endtask

   // Complete the issued instruction and check the resulting PC
   task automatic exec(input logic b, input logic n, input logic z, input logic [7:0] exp_pc);
      ex_done  = 1'b1;
      br       = b;
      nia      = n;
      alu_zero = z;
      tick();
      ex_done  = 1'b0;
      br       = 1'b0;
      nia      = 1'b0;
      alu_zero = 1'b0;
      chk("next_pc", pc, exp_pc);
      chk("next_addr", imem_bus.imem_addr, exp_pc);
      chk("next_req", imem_bus.imem_req, 1'b1);
      chk("iv_fall", instr_valid, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      ex_done = 1'b0;
      br = 1'b0;
      nia = 1'b0;
      alu_zero = 1'b0;
      imem_bus.imem_valid = 1'b0;
      imem_bus.imem_rdata = 16'h0000;

      // Reset state
      tick();
      chk("rst_req", imem_bus.imem_req, 1'b0);
      chk("rst_pc", pc, 8'h00);
      chk("rst_iv", instr_valid, 1'b0);
      chk("rst_halt", halted, 1'b0);
      rst = 1'b0;
      #1;

      // ADD at 0, zero-wait memory, 2-cycle period
      fetch(0, 16'h0000, 8'h00);
      chk("add_opfn", opFn, 5'b00000);
      exec(1'b0, 1'b1, 1'b0, 8'h01);

      // ex_done in FETCH is ignored
      ex_done = 1'b1;
      nia = 1'b1;
      tick();
      ex_done = 1'b0;
      nia = 1'b0;
      chk("exd_ign_pc", pc, 8'h01);

      // Jump to 5
      fetch(0, 16'hA005, 8'h01);
      chk("j_opfn", opFn, 5'b10101);
      exec(1'b0, 1'b0, 1'b0, 8'h05);

      // Three request cycles at address 5 before data arrives
      fetch(2, 16'hA010, 8'h05);
      // imem_valid during ISSUE is ignored
      imem_bus.imem_valid = 1'b1;
      imem_bus.imem_rdata = 16'h0000;
      tick();
      imem_bus.imem_valid = 1'b0;
      chk("ivalid_ign", opFn, 5'b10100);
      chk("ivalid_ign_iv", instr_valid, 1'b1);
      exec(1'b0, 1'b0, 1'b0, 8'h10);

      // BEQ imm -2 taken: 0x10 + 1 - 2
      fetch(0, 16'h807E, 8'h10);
      chk("beq_imm", imm, 8'hFE);
      chk("beq_opfn", opFn, 5'b10010);
      chk("beq_rd", rd, 3'd7);
      exec(1'b1, 1'b0, 1'b1, 8'h0F);
      fetch(0, 16'hA010, 8'h0F);
      exec(1'b0, 1'b0, 1'b0, 8'h10);
      // BEQ not taken
      fetch(0, 16'h807E, 8'h10);
      exec(1'b1, 1'b0, 1'b0, 8'h11);
      // br and nia both set: nia wins
      fetch(0, 16'h807E, 8'h11);
      exec(1'b1, 1'b1, 1'b1, 8'h12);

      // Jump to A5, then FF, then wrap with ADD
      fetch(0, 16'hA0A5, 8'h12);
      exec(1'b0, 1'b0, 1'b0, 8'hA5);
      fetch(0, 16'hA0FF, 8'hA5);
      exec(1'b0, 1'b0, 1'b0, 8'hFF);
      fetch(0, 16'h0000, 8'hFF);
      exec(1'b0, 1'b1, 1'b0, 8'h00);

      // Register field decode
      fetch(0, 16'h15E0, 8'h00);
      chk("rs", rs, 3'd5);
      chk("rt", rt, 3'd3);
      chk("rd", rd, 3'd6);
      exec(1'b0, 1'b1, 1'b0, 8'h01);
      fetch(0, 16'hA020, 8'h01);
      exec(1'b0, 1'b0, 1'b0, 8'h20);

      // Reserved opcode 3'b110 at 0x20
      fetch(0, 16'hC000, 8'h20);
      chk("ill_opfn", opFn, 5'b11000);
      tick();
`ifdef FETCH_TRAP_EN
      chk("trap_halt", halted, 1'b1);
      chk("trap_req", imem_bus.imem_req, 1'b0);
      chk("trap_iv", instr_valid, 1'b0);
      chk("trap_pc", pc, 8'h20);
      ex_done = 1'b1;
      tick();
      ex_done = 1'b0;
      chk("trap_hold", halted, 1'b1);
      chk("trap_pc2", pc, 8'h20);
`else
      chk("ill_nohalt", halted, 1'b0);
      chk("ill_wait_iv", instr_valid, 1'b1);
      // jump decision would go to 0x00; reserved opcode forces pc+1
      exec(1'b0, 1'b0, 1'b0, 8'h21);
`endif

      // Reset, then reset again while in ISSUE with ex_done high
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst2_halt", halted, 1'b0);
      fetch(0, 16'h0000, 8'h00);
      rst = 1'b1;
      ex_done = 1'b1;
      nia = 1'b1;
      tick();
      rst = 1'b0;
      ex_done = 1'b0;
      nia = 1'b0;
      #1;
      chk("rst_iss_pc", pc, 8'h00);
      chk("rst_iss_iv", instr_valid, 1'b0);
      chk("rst_iss_req", imem_bus.imem_req, 1'b1);
      chk("rst_iss_addr", imem_bus.imem_addr, 8'h00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
